arf_sample_feeder: RTL and testbench
====================================

ARF_SAMPLE_FEEDER -- requirements
Module: arf_sample_feeder

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample/result width in bits.
REQ-002 SHALL have parameter TAPS, default 8, delay-line depth (one tap per in_k_0 multiplier operand, k=1..8).
REQ-003 SHALL have ports: clk  input  1  sole clock, all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 flush  input  1  synchronous pipeline clear.
REQ-006 s_valid  input  1 / s_ready  output  1 / s_data  input  DATA_W  sample ingress handshake.
REQ-007 t_valid  output  1 / t_ready  input  1  tap-vector egress handshake toward the ARF datapath.
REQ-008 tap_0..tap_7  output  DATA_W each  delay-line taps, tap_0 newest; drive in_1_0..in_8_0.
REQ-009 fb_13, fb_14  output  DATA_W  recursive state operands; drive in_13_1, in_14_1.
REQ-010 r_valid  input  1 / r_27, r_28  input  DATA_W  datapath results out_27, out_28 returned.
REQ-011 vec_cnt  output  16  count of tap vectors delivered.

Function
REQ-012 Sample accepted iff s_valid && s_ready; on accept tap_k <= tap_(k-1) for k=1..7, tap_0 <= s_data, same edge.
REQ-013 fill_cnt (0..TAPS) increments per accept, saturates at TAPS.
REQ-014 FSM states: FILL, EMIT, WAIT_RES.
REQ-015 FILL: s_ready=1, t_valid=0; accept making fill_cnt==TAPS -> EMIT next cycle.
REQ-016 EMIT: s_ready=0, t_valid=1, taps and fb_* stable; t_ready -> WAIT_RES (feedback enabled) else FILL; vec_cnt +1 on that handshake, wraps 0xFFFF->0.
REQ-017 WAIT_RES: s_ready=0, t_valid=0; r_valid -> fb_13<=r_27, fb_14<=r_28, -> FILL.
REQ-018 Once fill_cnt==TAPS, each further accept in FILL -> EMIT (one vector per new sample, latency 1 cycle accept-to-t_valid).
REQ-019 t_valid, once high, SHALL stay high with unchanged taps until t_ready.
REQ-020 r_valid outside WAIT_RES SHALL be ignored; r_valid coincident with entry to WAIT_RES is not captured.
REQ-021 flush: taps, fb_*, fill_cnt cleared, state -> FILL next cycle; vec_cnt retained; priority over any same-cycle handshake (sample dropped, vector not counted).
REQ-022 s_ready and t_valid SHALL be decoded from registered state only (no combinational path from s_valid/t_ready).

Reset
REQ-023 rst_n low at clk edge: state FILL, fill_cnt=0, tap_0..tap_7=0, fb_13=fb_14=0, vec_cnt=0, t_valid=0, s_ready=1 after release.
REQ-024 Reset mid-transfer SHALL abandon the pending vector/result with no other side effect; rst_n has priority over flush.

Configuration
REQ-025 Macro ARF_FEEDBACK_EN defined: WAIT_RES present, fb_* loaded from r_27/r_28 per REQ-017.
REQ-026 Undefined: WAIT_RES removed, EMIT -> FILL directly, fb_13=fb_14=0 constant, r_* ignored.

Structure
REQ-027 Shared package arf_pkg SHALL hold DATA_W/TAPS defaults, FSM state enum type, tap-array typedef.
REQ-028 Delay line SHALL be sub-module arf_tap_line (shift-enable, clear, TAPS x DATA_W outputs); FSM, counters, feedback regs in top.

Verification
REQ-029 Reset, feed 1..8 with s_valid held, t_ready=1 -> t_valid 1 cycle after 8th accept, tap_0=8..tap_7=1, vec_cnt=1.
REQ-030 In EMIT hold t_ready=0 10 cycles with s_valid=1 -> s_ready=0, taps frozen, no sample consumed.
REQ-031 ARF_FEEDBACK_EN: after vector, r_valid with r_27=0x1234, r_28=0xBEEF -> fb_13=0x1234, fb_14=0xBEEF, next vector carries them; r_valid in FILL -> fb unchanged.
REQ-032 Flush with s_valid=1 in FILL at fill_cnt=5 -> taps 0, sample dropped, 8 fresh samples needed before t_valid.
REQ-033 Preload vec_cnt path with 65536 vectors -> vec_cnt wraps to 0.
REQ-034 Without ARF_FEEDBACK_EN: back-to-back vectors every 2 cycles, fb_*=0 despite r_valid.

Source files
------------

// File: rtl/arf_pkg.sv
// Shared types and defaults for the ARF sample feeder: width/depth defaults,
// the feeder FSM state type and the tap-array type.
package arf_pkg;

    localparam int ARF_DATA_W = 16;
    localparam int ARF_TAPS   = 8;

    typedef enum logic [1:0] {
        ST_FILL     = 2'd0,
        ST_EMIT     = 2'd1,
        ST_WAIT_RES = 2'd2
    } arf_state_t;

    typedef logic [ARF_DATA_W-1:0] arf_tap_arr_t [ARF_TAPS];

endpackage

// File: rtl/arf_tap_line.sv
// Shift-register delay line: tap 0 takes the new sample, every other tap
// takes its lower neighbour on a shift; clear and reset zero every tap.
module arf_tap_line
    import arf_pkg::*;
#(
    parameter int DATA_W = ARF_DATA_W,
    parameter int TAPS   = ARF_TAPS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_shift,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_taps [TAPS]
);

    logic [DATA_W-1:0] r_taps [TAPS];

    genvar gi;
    generate
        for (gi = 0; gi < TAPS; gi++) begin : g_tap
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (!rst_n || i_clear) begin
                        r_taps[gi] <= '0;
                    end else if (i_shift) begin
                        r_taps[gi] <= i_data;
                    end
                end
            end else begin : g_body
                always_ff @(posedge clk) begin
                    if (!rst_n || i_clear) begin
                        r_taps[gi] <= '0;
                    end else if (i_shift) begin
                        r_taps[gi] <= r_taps[gi-1];
                    end
                end
            end
            assign o_taps[gi] = r_taps[gi];
        end
    endgenerate

endmodule

// File: rtl/arf_sample_feeder.sv
// Collects TAPS samples into a delay line and offers them as one tap vector per new sample.
// Define ARF_FEEDBACK_EN to wait for out_27/out_28 after each vector and feed them back as fb_13/fb_14.
module arf_sample_feeder
    import arf_pkg::*;
#(
    parameter int          DATA_W       = ARF_DATA_W,
    parameter int          TAPS         = ARF_TAPS,
    parameter logic [15:0] VEC_CNT_INIT = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              t_valid,
    input  logic              t_ready,
    output logic [DATA_W-1:0] tap_0,
    output logic [DATA_W-1:0] tap_1,
    output logic [DATA_W-1:0] tap_2,
    output logic [DATA_W-1:0] tap_3,
    output logic [DATA_W-1:0] tap_4,
    output logic [DATA_W-1:0] tap_5,
    output logic [DATA_W-1:0] tap_6,
    output logic [DATA_W-1:0] tap_7,
    output logic [DATA_W-1:0] fb_13,
    output logic [DATA_W-1:0] fb_14,
    input  logic              r_valid,
    input  logic [DATA_W-1:0] r_27,
    input  logic [DATA_W-1:0] r_28,
    output logic [15:0]       vec_cnt
);

    localparam int FILL_W = $clog2(TAPS + 1);

    arf_state_t        r_state;
    logic [FILL_W-1:0] r_fill_cnt;
    logic [15:0]       r_vec_cnt;
    logic [DATA_W-1:0] w_taps [TAPS];
    logic [DATA_W-1:0] w_tap_out [8];
    logic              w_accept;
    logic              w_emit_hs;
    logic              w_line_full_next;

    // Handshake flags come from the registered state alone.
    assign s_ready          = (r_state == ST_FILL);
    assign t_valid          = (r_state == ST_EMIT);
    assign w_accept         = s_ready && s_valid && !flush;
    assign w_emit_hs        = t_valid && t_ready && !flush;
    assign w_line_full_next = (r_fill_cnt >= FILL_W'(TAPS - 1));
    assign vec_cnt          = r_vec_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_fill_cnt <= '0;
        end else if (w_accept && (r_fill_cnt != FILL_W'(TAPS))) begin
            r_fill_cnt <= r_fill_cnt + FILL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_state <= ST_FILL;
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (w_accept && w_line_full_next) begin
                        r_state <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (w_emit_hs) begin
`ifdef ARF_FEEDBACK_EN
                        r_state <= ST_WAIT_RES;
`else
                        r_state <= ST_FILL;
`endif
                    end
                end
`ifdef ARF_FEEDBACK_EN
                ST_WAIT_RES: begin
                    if (r_valid) begin
                        r_state <= ST_FILL;
                    end
                end
`endif
                default: r_state <= ST_FILL;
            endcase
        end
    end

    // Vector count survives flush; only reset restarts it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vec_cnt <= VEC_CNT_INIT;
        end else if (w_emit_hs) begin
            r_vec_cnt <= r_vec_cnt + 16'd1;
        end
    end

`ifdef ARF_FEEDBACK_EN
    logic [DATA_W-1:0] r_fb_13;
    logic [DATA_W-1:0] r_fb_14;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_fb_13 <= '0;
            r_fb_14 <= '0;
        end else if ((r_state == ST_WAIT_RES) && r_valid) begin
            r_fb_13 <= r_27;
            r_fb_14 <= r_28;
        end
    end

    assign fb_13 = r_fb_13;
    assign fb_14 = r_fb_14;
`else
    logic w_unused_result;

    assign w_unused_result = ^{r_valid, r_27, r_28};
    assign fb_13           = '0;
    assign fb_14           = '0;
`endif

    arf_tap_line #(
        .DATA_W (DATA_W),
        .TAPS   (TAPS)
    ) u_tap_line (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (flush),
        .i_shift (w_accept),
        .i_data  (s_data),
        .o_taps  (w_taps)
    );

    // A shallower line pads the unused upper taps with zero.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_tap_out
            if (gi < TAPS) begin : g_live
                assign w_tap_out[gi] = w_taps[gi];
            end else begin : g_pad
                assign w_tap_out[gi] = '0;
            end
        end
    endgenerate

    assign tap_0 = w_tap_out[0];
    assign tap_1 = w_tap_out[1];
    assign tap_2 = w_tap_out[2];
    assign tap_3 = w_tap_out[3];
    assign tap_4 = w_tap_out[4];
    assign tap_5 = w_tap_out[5];
    assign tap_6 = w_tap_out[6];
    assign tap_7 = w_tap_out[7];

endmodule

// File: tb/tb_arf_sample_feeder.sv
// Self-checking bench for arf_sample_feeder: directed scenarios plus randomized traffic
// against a sample-history model; a second instance preloads vec_cnt near wrap.
module tb_arf_sample_feeder;

    localparam int          NT        = 8;
    localparam logic [15:0] WRAP_INIT = 16'hFFFD;
`ifdef ARF_FEEDBACK_EN
    localparam bit FB_EN     = 1'b1;
    localparam int B2B_VECS  = 10;
`else
    localparam bit FB_EN     = 1'b0;
    localparam int B2B_VECS  = 15;
`endif

    logic        clk = 1'b0;
    logic        rst_n, flush, s_valid, t_ready, r_valid;
    logic [15:0] s_data, r_27, r_28;
    logic        s_ready, t_valid;
    logic [15:0] tap_0, tap_1, tap_2, tap_3, tap_4, tap_5, tap_6, tap_7;
    logic [15:0] fb_13, fb_14, vec_cnt;
    logic [15:0] d_tap [8];

    logic        w2_unused_s_ready, w2_unused_t_valid;
    logic [15:0] w2_unused_t0, w2_unused_t1, w2_unused_t2, w2_unused_t3;
    logic [15:0] w2_unused_t4, w2_unused_t5, w2_unused_t6, w2_unused_t7;
    logic [15:0] w2_unused_fb13, w2_unused_fb14, w2_vec_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model: the last TAPS accepted samples, newest first.
    logic [15:0] m_hist [$];
    bit          m_pending;
    bit          m_awaiting;
    logic [15:0] m_fb13, m_fb14;
    int          m_vec;

    always #5 clk = ~clk;

    assign d_tap[0] = tap_0;
    assign d_tap[1] = tap_1;
    assign d_tap[2] = tap_2;
    assign d_tap[3] = tap_3;
    assign d_tap[4] = tap_4;
    assign d_tap[5] = tap_5;
    assign d_tap[6] = tap_6;
    assign d_tap[7] = tap_7;

    arf_sample_feeder dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .t_valid(t_valid), .t_ready(t_ready),
        .tap_0(tap_0), .tap_1(tap_1), .tap_2(tap_2), .tap_3(tap_3),
        .tap_4(tap_4), .tap_5(tap_5), .tap_6(tap_6), .tap_7(tap_7),
        .fb_13(fb_13), .fb_14(fb_14),
        .r_valid(r_valid), .r_27(r_27), .r_28(r_28),
        .vec_cnt(vec_cnt)
    );

    arf_sample_feeder #(.VEC_CNT_INIT(WRAP_INIT)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .s_valid(s_valid), .s_ready(w2_unused_s_ready), .s_data(s_data),
        .t_valid(w2_unused_t_valid), .t_ready(t_ready),
        .tap_0(w2_unused_t0), .tap_1(w2_unused_t1), .tap_2(w2_unused_t2), .tap_3(w2_unused_t3),
        .tap_4(w2_unused_t4), .tap_5(w2_unused_t5), .tap_6(w2_unused_t6), .tap_7(w2_unused_t7),
        .fb_13(w2_unused_fb13), .fb_14(w2_unused_fb14),
        .r_valid(r_valid), .r_27(r_27), .r_28(r_28),
        .vec_cnt(w2_vec_cnt)
    );

    task automatic model_clear();
        m_hist.delete();
        m_pending  = 1'b0;
        m_awaiting = 1'b0;
        m_fb13     = 16'h0;
        m_fb14     = 16'h0;
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_clear();
            m_vec = 0;
        end else if (flush) begin
            model_clear();
        end else if (m_pending) begin
            if (t_ready) begin
                m_pending  = 1'b0;
                m_vec      = (m_vec + 1) % 65536;
                m_awaiting = FB_EN;
                $display("vector %0d delivered tap_0=%h tap_7=%h", m_vec, tap_0, tap_7);
            end
        end else if (m_awaiting) begin
            if (r_valid) begin
                m_fb13     = r_27;
                m_fb14     = r_28;
                m_awaiting = 1'b0;
            end
        end else if (s_valid) begin
            m_hist.push_front(s_data);
            if (m_hist.size() > NT) void'(m_hist.pop_back());
            if (m_hist.size() == NT) m_pending = 1'b1;
        end
    endtask

    function automatic logic [15:0] m_tap(input int k);
        return (k < m_hist.size()) ? m_hist[k] : 16'h0;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst_n = 1'b1; flush = 1'b0; s_valid = 1'b0; t_ready = 1'b0; r_valid = 1'b0;
        s_data = 16'h0; r_27 = 16'h0; r_28 = 16'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b1; s_valid = 1'b1; s_data = 16'h55AA;
        t_ready = 1'b1; r_valid = 1'b1; r_27 = 16'h1111; r_28 = 16'h2222;
        tick(); tick();
        idle_inputs();
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b expected 1", s_ready); end
        checks++; if (t_valid !== 1'b0) begin errors++; $display("FAIL reset_t_valid: got %b expected 0", t_valid); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (d_tap[k] !== 16'h0) begin errors++; $display("FAIL reset_tap_%0d: got %h expected 0000", k, d_tap[k]); end
        end
        checks++; if (fb_13 !== 16'h0 || fb_14 !== 16'h0) begin errors++; $display("FAIL reset_fb: got %h/%h expected 0000/0000", fb_13, fb_14); end
        checks++; if (vec_cnt !== 16'h0) begin errors++; $display("FAIL reset_vec_cnt: got %h expected 0000", vec_cnt); end
        checks++; if (w2_vec_cnt !== WRAP_INIT) begin errors++; $display("FAIL reset_vec_preload: got %h expected %h", w2_vec_cnt, WRAP_INIT); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            s_valid = 1'b1; s_data = 16'(i); t_ready = 1'b1;
            tick();
            if (i < 8) begin
                checks++; if (t_valid !== 1'b0) begin errors++; $display("FAIL fill_early_t_valid: sample %0d got %b expected 0", i, t_valid); end
            end
        end
        checks++; if (t_valid !== 1'b1 || s_ready !== 1'b0) begin errors++; $display("FAIL fill_emit: got t_valid=%b s_ready=%b expected 1/0", t_valid, s_ready); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (d_tap[k] !== 16'(8 - k)) begin errors++; $display("FAIL fill_tap_%0d: got %h expected %h", k, d_tap[k], 16'(8 - k)); end
        end
        s_valid = 1'b0;
        tick();
        t_ready = 1'b0;
        checks++; if (vec_cnt !== 16'd1) begin errors++; $display("FAIL fill_vec_cnt: got %0d expected 1", vec_cnt); end
        checks++; if (t_valid !== 1'b0) begin errors++; $display("FAIL fill_t_valid_drop: got %b expected 0", t_valid); end
    endtask

    task automatic test_feedback();
`ifdef ARF_FEEDBACK_EN
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL fb_wait_s_ready: got %b expected 0", s_ready); end
        r_valid = 1'b1; r_27 = 16'h1234; r_28 = 16'hBEEF;
        tick();
        r_valid = 1'b0;
        checks++; if (fb_13 !== 16'h1234 || fb_14 !== 16'hBEEF) begin errors++; $display("FAIL fb_capture: got %h/%h expected 1234/beef", fb_13, fb_14); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL fb_return_fill: got s_ready=%b expected 1", s_ready); end
        s_valid = 1'b1; s_data = 16'd9;
        tick();
        s_valid = 1'b0;
        checks++; if (t_valid !== 1'b1 || fb_13 !== 16'h1234 || fb_14 !== 16'hBEEF) begin errors++; $display("FAIL fb_in_vector: got t_valid=%b fb=%h/%h expected 1 1234/beef", t_valid, fb_13, fb_14); end
        checks++; if (tap_0 !== 16'd9 || tap_7 !== 16'd2) begin errors++; $display("FAIL fb_vector_taps: got %h/%h expected 0009/0002", tap_0, tap_7); end
        t_ready = 1'b1; r_valid = 1'b1; r_27 = 16'hDEAD; r_28 = 16'hBEAD;
        tick();
        t_ready = 1'b0;
        checks++; if (s_ready !== 1'b0 || fb_13 !== 16'h1234) begin errors++; $display("FAIL fb_entry_ignored: got s_ready=%b fb_13=%h expected 0 1234", s_ready, fb_13); end
        r_27 = 16'hAAAA; r_28 = 16'h5555;
        tick();
        r_valid = 1'b0;
        checks++; if (fb_13 !== 16'hAAAA || fb_14 !== 16'h5555) begin errors++; $display("FAIL fb_second_capture: got %h/%h expected aaaa/5555", fb_13, fb_14); end
        r_valid = 1'b1; r_27 = 16'h1111; r_28 = 16'h2222;
        tick();
        r_valid = 1'b0;
        checks++; if (fb_13 !== 16'hAAAA || fb_14 !== 16'h5555) begin errors++; $display("FAIL fb_ignored_in_fill: got %h/%h expected aaaa/5555", fb_13, fb_14); end
`else
        s_valid = 1'b1; s_data = 16'd9; r_valid = 1'b1; r_27 = 16'h1234; r_28 = 16'hBEEF;
        tick();
        s_valid = 1'b0;
        checks++; if (t_valid !== 1'b1 || fb_13 !== 16'h0 || fb_14 !== 16'h0) begin errors++; $display("FAIL nofb_emit: got t_valid=%b fb=%h/%h expected 1 0000/0000", t_valid, fb_13, fb_14); end
        t_ready = 1'b1;
        tick();
        t_ready = 1'b0; r_valid = 1'b0;
        checks++; if (fb_13 !== 16'h0 || fb_14 !== 16'h0) begin errors++; $display("FAIL nofb_fb_zero: got %h/%h expected 0000/0000", fb_13, fb_14); end
        checks++; if (vec_cnt !== 16'd2 || s_ready !== 1'b1) begin errors++; $display("FAIL nofb_direct_fill: got vec=%0d s_ready=%b expected 2 1", vec_cnt, s_ready); end
`endif
    endtask

    task automatic test_hold();
        s_valid = 1'b1; s_data = 16'h0A00; t_ready = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            s_data = 16'($urandom);
            tick();
            checks++; if (s_ready !== 1'b0 || t_valid !== 1'b1) begin errors++; $display("FAIL hold_flags: cycle %0d got s_ready=%b t_valid=%b expected 0/1", i, s_ready, t_valid); end
            for (int k = 0; k < 8; k++) begin
                checks++; if (d_tap[k] !== m_tap(k)) begin errors++; $display("FAIL hold_tap_%0d: cycle %0d got %h expected %h", k, i, d_tap[k], m_tap(k)); end
            end
        end
        s_valid = 1'b0; t_ready = 1'b1;
        tick();
        t_ready = 1'b0;
        checks++; if (vec_cnt !== 16'd3) begin errors++; $display("FAIL hold_vec_cnt: got %0d expected 3", vec_cnt); end
        checks++; if (tap_0 !== 16'h0A00 || tap_1 !== 16'd9) begin errors++; $display("FAIL hold_no_consume: got %h/%h expected 0a00/0009", tap_0, tap_1); end
`ifdef ARF_FEEDBACK_EN
        r_valid = 1'b1; r_27 = 16'($urandom); r_28 = 16'($urandom);
        tick();
        r_valid = 1'b0;
`endif
    endtask

    task automatic test_back_to_back();
        int  vec0;
        bit  exp_tv;
        vec0 = m_vec;
        for (int i = 1; i <= 30; i++) begin
            s_valid = 1'b1; t_ready = 1'b1; r_valid = 1'b1;
            s_data = 16'($urandom); r_27 = 16'($urandom); r_28 = 16'($urandom);
            tick();
`ifdef ARF_FEEDBACK_EN
            exp_tv = (i % 3 == 1);
`else
            exp_tv = (i % 2 == 1);
`endif
            checks++; if (t_valid !== exp_tv) begin errors++; $display("FAIL b2b_t_valid: cycle %0d got %b expected %b", i, t_valid, exp_tv); end
            checks++; if (fb_13 !== m_fb13 || fb_14 !== m_fb14) begin errors++; $display("FAIL b2b_fb: cycle %0d got %h/%h expected %h/%h", i, fb_13, fb_14, m_fb13, m_fb14); end
        end
        idle_inputs();
        checks++; if (vec_cnt !== 16'(vec0 + B2B_VECS)) begin errors++; $display("FAIL b2b_vec_cnt: got %0d expected %0d", vec_cnt, vec0 + B2B_VECS); end
    endtask

    task automatic test_flush();
        int vec0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            s_valid = 1'b1; s_data = 16'(16'h100 + i);
            tick();
        end
        vec0 = m_vec;
        flush = 1'b1; s_data = 16'h7777;
        tick();
        flush = 1'b0; s_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++; if (d_tap[k] !== 16'h0) begin errors++; $display("FAIL flush_tap_%0d: got %h expected 0000", k, d_tap[k]); end
        end
        checks++; if (s_ready !== 1'b1 || vec_cnt !== 16'(vec0)) begin errors++; $display("FAIL flush_state: got s_ready=%b vec=%0d expected 1 %0d", s_ready, vec_cnt, vec0); end
        for (int i = 1; i <= 8; i++) begin
            s_valid = 1'b1; s_data = 16'(16'h200 + i);
            tick();
            if (i < 8) begin
                checks++; if (t_valid !== 1'b0) begin errors++; $display("FAIL flush_refill_early: sample %0d got t_valid=%b expected 0", i, t_valid); end
            end
        end
        s_valid = 1'b0;
        checks++; if (t_valid !== 1'b1 || tap_0 !== 16'h208 || tap_7 !== 16'h201) begin errors++; $display("FAIL flush_refill: got t_valid=%b taps %h..%h expected 1 0208..0201", t_valid, tap_0, tap_7); end
        flush = 1'b1; t_ready = 1'b1;
        tick();
        flush = 1'b0; t_ready = 1'b0;
        checks++; if (vec_cnt !== 16'(vec0) || t_valid !== 1'b0 || s_ready !== 1'b1) begin errors++; $display("FAIL flush_over_handshake: got vec=%0d t_valid=%b s_ready=%b expected %0d 0 1", vec_cnt, t_valid, s_ready, vec0); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst_n   = ($urandom_range(149) != 0);
            flush   = ($urandom_range(39) == 0);
            s_valid = ($urandom_range(99) < 70);
            t_ready = ($urandom_range(99) < 50);
            r_valid = ($urandom_range(99) < 30);
            s_data  = 16'($urandom);
            r_27    = 16'($urandom);
            r_28    = 16'($urandom);
            tick();
            checks++; if (s_ready !== !(m_pending || m_awaiting)) begin errors++; $display("FAIL rnd_s_ready: cycle %0d got %b expected %b", i, s_ready, !(m_pending || m_awaiting)); end
            checks++; if (t_valid !== m_pending) begin errors++; $display("FAIL rnd_t_valid: cycle %0d got %b expected %b", i, t_valid, m_pending); end
            for (int k = 0; k < 8; k++) begin
                checks++; if (d_tap[k] !== m_tap(k)) begin errors++; $display("FAIL rnd_tap_%0d: cycle %0d got %h expected %h", k, i, d_tap[k], m_tap(k)); end
            end
            checks++; if (fb_13 !== m_fb13 || fb_14 !== m_fb14) begin errors++; $display("FAIL rnd_fb: cycle %0d got %h/%h expected %h/%h", i, fb_13, fb_14, m_fb13, m_fb14); end
            checks++; if (vec_cnt !== 16'(m_vec)) begin errors++; $display("FAIL rnd_vec_cnt: cycle %0d got %0d expected %0d", i, vec_cnt, 16'(m_vec)); end
            checks++; if (w2_vec_cnt !== 16'(m_vec + int'(WRAP_INIT))) begin errors++; $display("FAIL rnd_vec_preload: cycle %0d got %h expected %h", i, w2_vec_cnt, 16'(m_vec + int'(WRAP_INIT))); end
        end
        idle_inputs();
    endtask

    task automatic test_wrap();
        int n;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (w2_vec_cnt !== WRAP_INIT || vec_cnt !== 16'h0) begin errors++; $display("FAIL wrap_start: got %h/%h expected %h/0000", w2_vec_cnt, vec_cnt, WRAP_INIT); end
        n = 0;
        while (m_vec < 3 && n < 100) begin
            s_valid = 1'b1; t_ready = 1'b1; r_valid = 1'b1; s_data = 16'($urandom);
            tick();
            n++;
        end
        checks++; if (m_vec != 3) begin errors++; $display("FAIL wrap_timeout: got %0d vectors expected 3", m_vec); end
        checks++; if (w2_vec_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_to_zero: got %h expected 0000", w2_vec_cnt); end
        n = 0;
        while (m_vec < 4 && n < 100) begin
            tick();
            n++;
        end
        idle_inputs();
        checks++; if (w2_vec_cnt !== 16'h0001 || vec_cnt !== 16'd4) begin errors++; $display("FAIL wrap_past_zero: got %h/%0d expected 0001/4", w2_vec_cnt, vec_cnt); end
    endtask

    initial begin
        idle_inputs();
        model_clear();
        m_vec = 0;
        @(negedge clk);
        test_reset();
        test_fill();
        test_feedback();
        test_hold();
        test_back_to_back();
        test_flush();
        test_random();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
